// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: memory-op encoding and classification helpers.
package mips_pkg;

    typedef enum logic [3:0] {
        MEM_NONE  = 4'd0,
        MEM_LB    = 4'd1,
        MEM_LBU   = 4'd2,
        MEM_LH    = 4'd3,
        MEM_LHU   = 4'd4,
        MEM_LW    = 4'd5,
        MEM_SB    = 4'd6,
        MEM_SH    = 4'd7,
        MEM_SW    = 4'd8,
        MEM_RSV9  = 4'd9,
        MEM_RSV10 = 4'd10,
        MEM_RSV11 = 4'd11,
        MEM_RSV12 = 4'd12,
        MEM_RSV13 = 4'd13,
        MEM_RSV14 = 4'd14,
        MEM_RSV15 = 4'd15
    } mem_op_e;

    function automatic logic is_load(input mem_op_e op);
        case (op)
            MEM_LB, MEM_LBU, MEM_LH, MEM_LHU, MEM_LW: return 1'b1;
            default:                                  return 1'b0;
        endcase
    endfunction

    function automatic logic is_store(input mem_op_e op);
        case (op)
            MEM_SB, MEM_SH, MEM_SW: return 1'b1;
            default:                return 1'b0;
        endcase
    endfunction

    // Byte ops are always aligned; halfwords need addr[0]=0, words addr[1:0]=0.
    function automatic logic isAligned(input mem_op_e op, input logic [1:0] addrLo);
        case (op)
            MEM_LH, MEM_LHU, MEM_SH: return ~addrLo[0];
            MEM_LW, MEM_SW:          return (addrLo == 2'b00);
            default:                 return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/load_extender.sv
// Little-endian lane select and sign/zero extension of bus read data for loads.
module load_extender
    import mips_pkg::*;
(
    input  mem_op_e     memOp,
    input  logic [1:0]  addrLo,
    input  logic [31:0] rdata,
    output logic [31:0] loadData
);

    logic [7:0]  byteSel;
    logic [15:0] halfSel;

    always_comb begin
        byteSel  = rdata[{addrLo, 3'b000} +: 8];
        halfSel  = addrLo[1] ? rdata[31:16] : rdata[15:0];
        loadData = 32'd0;
        case (memOp)
            MEM_LB:  loadData = {{24{byteSel[7]}}, byteSel};
            MEM_LBU: loadData = {24'd0, byteSel};
            MEM_LH:  loadData = {{16{halfSel[15]}}, halfSel};
            MEM_LHU: loadData = {16'd0, halfSel};
            MEM_LW:  loadData = rdata;
            default: loadData = 32'd0;
        endcase
    end

endmodule

// File: rtl/mem_access_stage.sv
// MIPS MEM stage: turns EX/MEM results into one valid/ack data-memory transaction,
// stalling the pipeline until it completes, times out, or is rejected as misaligned.
module mem_access_stage
    import mips_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        valid_i,
    input  logic [3:0]  mem_op_i,
    input  logic [31:0] alu_result_i,
    input  logic [31:0] store_data_i,
    output logic [29:0] mem_addr_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_wdata_o,
    input  logic [31:0] mem_rdata_i,
    input  logic        mem_ack_i,
    output logic        stall_o,
    output logic [31:0] load_data_o,
    output logic [31:0] alu_pass_o,
    output logic        addr_err_o,
    output logic        bus_err_o
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

    state_e      state, stateNext;
    mem_op_e     op, reqOp;
    logic [1:0]  reqAddrLo;
    logic [7:0]  cnt, cntNext;
    logic        isMem, aligned, accept, ackHit, timedOut;
    logic [31:0] extData;

    function automatic logic [7:0] satInc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    function automatic logic [3:0] byteEnable(input mem_op_e o, input logic [1:0] a);
        case (o)
            MEM_LB, MEM_LBU, MEM_SB: return 4'b0001 << a;
            MEM_LH, MEM_LHU, MEM_SH: return 4'b0011 << a;
            MEM_LW, MEM_SW:          return 4'b1111;
            default:                 return 4'b0000;
        endcase
    endfunction

    function automatic logic [31:0] laneData(input mem_op_e o, input logic [31:0] d);
        case (o)
            MEM_SB:  return {4{d[7:0]}};
            MEM_SH:  return {2{d[15:0]}};
            MEM_SW:  return d;
            default: return 32'd0;
        endcase
    endfunction

    assign op         = mem_op_e'(mem_op_i);
    assign isMem      = is_load(op) | is_store(op);
    assign aligned    = isAligned(op, alu_result_i[1:0]);
    assign accept     = (state == IDLE) & valid_i & isMem & aligned;
    assign addr_err_o = (state == IDLE) & valid_i & isMem & ~aligned;
    assign stall_o    = valid_i & isMem & aligned & (state != DONE);
    assign alu_pass_o = alu_result_i;

    load_extender u_load_extender (
        .memOp    (reqOp),
        .addrLo   (reqAddrLo),
        .rdata    (mem_rdata_i),
        .loadData (extData)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= 8'd0;
        end else begin
            state <= stateNext;
            cnt   <= cntNext;
        end
    end

    // Ack wins over a timeout landing in the same cycle.
    always_comb begin
        stateNext = state;
        cntNext   = cnt;
        ackHit    = 1'b0;
        timedOut  = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    stateNext = BUSY;
                    cntNext   = 8'd0;
                end
            end
            BUSY: begin
                cntNext = satInc(cnt);
                if (mem_ack_i) begin
                    ackHit    = 1'b1;
                    stateNext = DONE;
                end else if (cntNext >= 8'(TIMEOUT)) begin
                    timedOut  = 1'b1;
                    stateNext = DONE;
                end
            end
            DONE:    stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    // Bus outputs latch at accept and stay frozen for the whole BUSY phase.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem_req_o   <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_be_o    <= 4'd0;
            mem_addr_o  <= 30'd0;
            mem_wdata_o <= 32'd0;
            reqOp       <= MEM_NONE;
            reqAddrLo   <= 2'd0;
            load_data_o <= 32'd0;
            bus_err_o   <= 1'b0;
        end else begin
            bus_err_o <= timedOut;
            if (accept) begin
                mem_req_o   <= 1'b1;
                mem_we_o    <= is_store(op);
                mem_be_o    <= byteEnable(op, alu_result_i[1:0]);
                mem_addr_o  <= alu_result_i[31:2];
                mem_wdata_o <= laneData(op, store_data_i);
                reqOp       <= op;
                reqAddrLo   <= alu_result_i[1:0];
            end else if (ackHit || timedOut) begin
                mem_req_o <= 1'b0;
            end
            // Load result lives only in DONE so MEM/WB never sees a stale value.
            if (ackHit && is_load(reqOp)) begin
                load_data_o <= extData;
            end else if (state == DONE) begin
                load_data_o <= 32'd0;
            end
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// Scoreboard bench for mem_access_stage: queued bus/result expectations checked as the DUT produces them.
module tb_mem_access_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid_i;
    logic [3:0]  mem_op_i;
    logic [31:0] alu_result_i;
    logic [31:0] store_data_i;
    logic [29:0] mem_addr_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_wdata_o;
    logic [31:0] mem_rdata_i;
    logic        mem_ack_i;
    logic        stall_o;
    logic [31:0] load_data_o;
    logic [31:0] alu_pass_o;
    logic        addr_err_o;
    logic        bus_err_o;

    typedef struct {
        logic [29:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
    } req_t;

    typedef struct {
        logic [31:0] load;
        logic        busErr;
        logic        addrErr;
        int          stalls;
    } res_t;

    req_t reqQ[$];
    res_t resQ[$];
    int   nChecks = 0;
    int   nFails  = 0;
    logic prevReq = 1'b0;

    mem_access_stage #(.TIMEOUT(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .valid_i      (valid_i),
        .mem_op_i     (mem_op_i),
        .alu_result_i (alu_result_i),
        .store_data_i (store_data_i),
        .mem_addr_o   (mem_addr_o),
        .mem_req_o    (mem_req_o),
        .mem_we_o     (mem_we_o),
        .mem_be_o     (mem_be_o),
        .mem_wdata_o  (mem_wdata_o),
        .mem_rdata_i  (mem_rdata_i),
        .mem_ack_i    (mem_ack_i),
        .stall_o      (stall_o),
        .load_data_o  (load_data_o),
        .alu_pass_o   (alu_pass_o),
        .addr_err_o   (addr_err_o),
        .bus_err_o    (bus_err_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nChecks++;
        if (got !== exp) begin
            nFails++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // Request monitor: each new request strobe is matched against the queued expectation.
    always @(negedge clk) begin
        if (mem_req_o && !prevReq) begin
            if (reqQ.size() == 0) begin
                chk("unexpected_req", 32'(mem_req_o), 32'd0);
            end else begin
                req_t r;
                r = reqQ.pop_front();
                chk("req_addr", 32'(mem_addr_o), 32'(r.addr));
                chk("req_we", 32'(mem_we_o), 32'(r.we));
                chk("req_be", 32'(mem_be_o), 32'(r.be));
                if (r.we) chk("req_wdata", mem_wdata_o, r.wdata);
            end
        end
        prevReq <= mem_req_o;
    end

    // Presents one op at posedge+1, acks in the ackAt-th BUSY cycle (0 = never).
    task automatic runOp(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] sdata,
                         input logic [31:0] rdata, input int ackAt, input bit eReq,
                         input logic eWe, input logic [3:0] eBe, input logic [31:0] eWdata,
                         input logic [31:0] eLoad, input logic eBusErr, input logic eAddrErr,
                         input int eStalls);
        req_t r;
        res_t e;
        int   stalls = 0;
        int   nBusy  = 0;
        bit   done   = 0;
        if (eReq) begin
            r.addr = addr[31:2]; r.we = eWe; r.be = eBe; r.wdata = eWdata;
            reqQ.push_back(r);
        end
        e.load = eLoad; e.busErr = eBusErr; e.addrErr = eAddrErr; e.stalls = eStalls;
        resQ.push_back(e);
        valid_i = 1'b1; mem_op_i = op; alu_result_i = addr; store_data_i = sdata;
        @(negedge clk);
        chk("alu_pass", alu_pass_o, addr);
        for (int cyc = 0; cyc < 40; cyc++) begin
            if (!stall_o) begin
                done = 1;
                break;
            end
            stalls++;
            chk("bus_err_busy", 32'(bus_err_o), 32'd0);
            if (mem_req_o) begin
                nBusy++;
                if (nBusy == ackAt) begin
                    mem_ack_i = 1'b1; mem_rdata_i = rdata;
                end
            end
            @(posedge clk); #1;
            mem_ack_i = 1'b0; mem_rdata_i = 32'h0;
            @(negedge clk);
        end
        chk("completes", 32'(done), 32'd1);
        e = resQ.pop_front();
        chk("stall_cycles", 32'(stalls), 32'(e.stalls));
        chk("load_data", load_data_o, e.load);
        chk("bus_err", 32'(bus_err_o), 32'(e.busErr));
        chk("addr_err", 32'(addr_err_o), 32'(e.addrErr));
        chk("req_dropped", 32'(mem_req_o), 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        rst_n = 1'b0; valid_i = 1'b0; mem_op_i = 4'd0; alu_result_i = 32'd0;
        store_data_i = 32'd0; mem_rdata_i = 32'd0; mem_ack_i = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_req", 32'(mem_req_o), 32'd0);
        chk("rst_we", 32'(mem_we_o), 32'd0);
        chk("rst_be", 32'(mem_be_o), 32'd0);
        chk("rst_addr", 32'(mem_addr_o), 32'd0);
        chk("rst_wdata", mem_wdata_o, 32'd0);
        chk("rst_load", load_data_o, 32'd0);
        chk("rst_bus_err", 32'(bus_err_o), 32'd0);
        chk("rst_stall", 32'(stall_o), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        //    op     addr          sdata         rdata        ack req we be       wdata         load          be ae stalls
        runOp(4'd5, 32'h0000_0100, 32'h0,        32'hDEADBEEF, 3, 1, 0, 4'b1111, 32'h0,        32'hDEADBEEF, 0, 0, 4);
        runOp(4'd1, 32'h0000_0103, 32'h0,        32'h80000000, 1, 1, 0, 4'b1000, 32'h0,        32'hFFFFFF80, 0, 0, 2);
        runOp(4'd2, 32'h0000_0103, 32'h0,        32'h80000000, 1, 1, 0, 4'b1000, 32'h0,        32'h00000080, 0, 0, 2);
        runOp(4'd7, 32'h0000_0202, 32'h1234ABCD, 32'h0,        2, 1, 1, 4'b1100, 32'hABCDABCD, 32'h0,        0, 0, 3);
        runOp(4'd5, 32'h0000_0101, 32'h0,        32'h0,        1, 0, 0, 4'b0000, 32'h0,        32'h0,        0, 1, 0);
        valid_i = 1'b0;
        @(negedge clk);
        chk("addr_err_one_cycle", 32'(addr_err_o), 32'd0);
        chk("misaligned_no_req", 32'(mem_req_o), 32'd0);
        @(posedge clk); #1;
        runOp(4'd5, 32'h0000_0010, 32'h0,        32'h0,        0, 1, 0, 4'b1111, 32'h0,        32'h0,        1, 0, 5);
        runOp(4'd3, 32'h0000_0006, 32'h0,        32'h80017FFF, 1, 1, 0, 4'b1100, 32'h0,        32'hFFFF8001, 0, 0, 2);
        runOp(4'd4, 32'h0000_0004, 32'h0,        32'h1234F00D, 2, 1, 0, 4'b0011, 32'h0,        32'h0000F00D, 0, 0, 3);
        runOp(4'd6, 32'h0000_0001, 32'h000000A5, 32'h0,        1, 1, 1, 4'b0010, 32'hA5A5A5A5, 32'h0,        0, 0, 2);
        runOp(4'd8, 32'h0000_0008, 32'hCAFEF00D, 32'h0,        1, 1, 1, 4'b1111, 32'hCAFEF00D, 32'h0,        0, 0, 2);
        runOp(4'd3, 32'h0000_0003, 32'h0,        32'h0,        1, 0, 0, 4'b0000, 32'h0,        32'h0,        0, 1, 0);
        runOp(4'd0, 32'h1234_5678, 32'h0,        32'h0,        1, 0, 0, 4'b0000, 32'h0,        32'h0,        0, 0, 0);
        runOp(4'd12, 32'h0000_0101, 32'h0,       32'h0,        1, 0, 0, 4'b0000, 32'h0,        32'h0,        0, 0, 0);

        // Reset while BUSY, with a late ack arriving right after reset.
        r_push: begin
            req_t r;
            r.addr = 30'h10; r.we = 1'b0; r.be = 4'b1111; r.wdata = 32'h0;
            reqQ.push_back(r);
        end
        valid_i = 1'b1; mem_op_i = 4'd5; alu_result_i = 32'h0000_0040;
        @(posedge clk); #1;
        @(negedge clk);
        chk("busy_req", 32'(mem_req_o), 32'd1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1; valid_i = 1'b0; mem_ack_i = 1'b1; mem_rdata_i = 32'hFFFF_FFFF;
        @(negedge clk);
        chk("rst_busy_req", 32'(mem_req_o), 32'd0);
        chk("rst_busy_load", load_data_o, 32'd0);
        @(posedge clk); #1;
        mem_ack_i = 1'b0; mem_rdata_i = 32'h0;
        @(negedge clk);
        chk("late_ack_load", load_data_o, 32'd0);
        chk("late_ack_req", 32'(mem_req_o), 32'd0);
        chk("late_ack_bus_err", 32'(bus_err_o), 32'd0);

        chk("req_queue_drained", 32'(reqQ.size()), 32'd0);
        chk("res_queue_drained", 32'(resQ.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", nChecks, nFails);
        $finish;
    end

endmodule

// File: doc/mem_access_stage.md
# mem_access_stage

Memory-access (MEM) stage of the 5-stage MIPS pipeline, between the EX/MEM pipeline register and the MEM/WB pipeline register. It turns the EX-stage ALU result and store data into a single data-memory transaction over a valid/ack bus. It performs byte/halfword/word alignment, byte-enable generation and load sign/zero extension. It stalls the pipeline while a transaction is outstanding.

## Interface
- TIMEOUT, 255: cycles without ack_i before a transaction is aborted (1..255).
- clk  in  1  pipeline clock; everything updates on posedge.
- rst_n  in  1  synchronous active-low reset.
- valid_i  in  1  EX/MEM holds a live instruction.
- mem_op_i  in  4  0 none, 1 LB, 2 LBU, 3 LH, 4 LHU, 5 LW, 6 SB, 7 SH, 8 SW; 9..15 treated as none.
- alu_result_i  in  32  effective address, or result for non-memory ops.
- store_data_i  in  32  rt value for stores.
- mem_addr_o  out  30  word address (alu_result_i[31:2]).
- mem_req_o  out  1  request strobe, registered.
- mem_we_o  out  1  1 = write.
- mem_be_o  out  4  byte enables, bit n = byte lane n.
- mem_wdata_o  out  32  lane-replicated store data.
- mem_rdata_i  in  32  read data, valid with mem_ack_i.
- mem_ack_i  in  1  one-cycle completion pulse.
- stall_o  out  1  hold EX/MEM and upstream stages; MEM/WB must not capture.
- load_data_o  out  32  extended load result, to MEM/WB dataOutput.
- alu_pass_o  out  32  alu_result_i pass-through, to MEM/WB dataInput.
- addr_err_o  out  1  misaligned access flagged this cycle.
- bus_err_o  out  1  timeout abort flagged this cycle.

## Operation
- Little-endian; byte lane n = addr[1:0]==n.
- Alignment: LH/LHU/SH need addr[0]=0; LW/SW need addr[1:0]=0. A misaligned op issues no request. addr_err_o pulses for the one cycle the op is presented, with stall_o=0, and load_data_o=0.
- Byte enables: byte 4'b0001<<a; half 4'b0011<<a; word 4'b1111. mem_wdata_o: SB {4{b}}, SH {2{h}}, SW data.
- Load extend: select the lane(s) from rdata; LB/LH sign-extend, LBU/LHU zero-extend.
- FSM states IDLE, BUSY, DONE.
  - IDLE: valid aligned memory op → register addr/be/we/wdata, set mem_req_o, go to BUSY; clear timeout counter.
  - BUSY: mem_req_o and all bus outputs held stable. On mem_ack_i, capture the extended load data (stores capture nothing), drop mem_req_o, go to DONE. If the counter reaches TIMEOUT first, drop the request, pulse bus_err_o, set load_data_o=0, go to DONE.
  - DONE: unconditionally back to IDLE next cycle.
- stall_o = valid memory op present AND state != DONE. Non-memory ops and invalid slots never stall, and alu_pass_o is combinational.
- mem_ack_i in IDLE or DONE is ignored.

## Timing
- Reset values: state IDLE, mem_req_o 0, mem_we_o 0, mem_be_o 0, mem_addr_o 0, mem_wdata_o 0, load_data_o 0, bus_err_o 0, counter 0.
- The request appears 1 cycle after the op is presented. With ack in the first BUSY cycle, a load costs 2 stall cycles, and the result is visible in DONE with stall_o=0.
- Back-to-back memory ops: the next op is accepted in the IDLE that follows DONE, so there is no overlap.
- Reset in BUSY: mem_req_o is 0 the next cycle, and a late ack is discarded.
- The timeout counter is 8 bits, saturating. bus_err_o is asserted only in DONE.

## Structure
- Shared package mips_pkg: mem_op enum (the 16 codes above) and an is_load/is_store helper function.
- One natural sub-module, load_extender: combinational lane select plus extension from (mem_op, addr[1:0], rdata).
- FSM, byte-enable/wdata generation and counter live in the top module.

## Test plan
- LW addr 0x100, ack after 3 cycles, rdata 0xDEADBEEF → mem_addr_o 0x40, be 1111, stall for 4 cycles, load_data_o 0xDEADBEEF in DONE.
- LB addr 0x103, rdata 0x80000000 → be 1000, load_data_o 0xFFFFFF80; LBU same → 0x00000080.
- SH addr 0x202, data 0x1234ABCD → we 1, be 1100, wdata 0xABCDABCD.
- LW addr 0x101 → no mem_req_o, addr_err_o=1 for one cycle, stall_o 0.
- No ack for TIMEOUT=4 → request dropped after 4 BUSY cycles, bus_err_o pulse, load_data_o 0, pipeline resumes.
- rst_n low during BUSY, ack arrives the next cycle → state IDLE, mem_req_o 0, load_data_o stays 0.
